// File: rtl/fetch_pkg.sv
// Shared constants and types for the macroblock fetch path (read address/data).
package fetch_pkg;

    localparam logic [7:0]  AR_LEN        = 8'd2;
    localparam logic [2:0]  AR_SIZE       = 3'd7;
    localparam logic [1:0]  AR_BURST_INCR = 2'b01;
    localparam int          MB_STRIDE     = 512;
    localparam int          MB_BEATS      = 3;
    localparam logic [63:0] MB_STRIDE_B   = 64'(MB_STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        DONE
    } fetch_state_e;

    // A macroblock base must sit on its 512 B stride so no burst crosses 4 KB.
    function automatic logic mb_aligned(input logic [63:0] addr);
        return addr[8:0] == 9'd0;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down in-flight counter bounded to [0, MAX]; coincident inc/dec cancel.
module credit_counter #(
    parameter int MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc,
    input  logic                       dec,
    output logic [$clog2(MAX+1)-1:0]   count
);

    localparam int             CW    = $clog2(MAX + 1);
    localparam logic [CW-1:0]  MAX_C = CW'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && count != MAX_C) begin
            count <= count + CW'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/raddr_channel.sv
// AXI AR generator: one 3-beat INCR burst per macroblock, in-flight bursts credit-limited.
module raddr_channel #(
    parameter int ID_WIDTH        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_pulse,
    input  logic [63:0]         src_addr,
    input  logic [15:0]         mb_num,
    input  logic                rlast_hs,
    output logic [63:0]         m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic [ID_WIDTH-1:0] m_axi_arid,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic                busy,
    output logic                done,
    output logic                addr_error
);

    import fetch_pkg::*;

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e  state, state_nxt;
    logic [15:0]   mb_cnt;
    logic [15:0]   issued;
    logic [15:0]   completed;
    logic [15:0]   completed_nxt;
    logic [OW-1:0] outstanding;
    logic          ar_hs;
    logic          start_acc;
    logic          start_ok;
    logic          rl_cnt;
    logic          credit_ok;

    assign m_axi_arlen   = AR_LEN;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = AR_BURST_INCR;
    assign m_axi_arid    = '0;

    assign start_acc     = start_pulse && (state == IDLE);
    assign start_ok      = mb_aligned(src_addr);
    assign rl_cnt        = rlast_hs && busy;
    assign completed_nxt = completed + {15'd0, rl_cnt};
    assign credit_ok     = outstanding < OW'(MAX_OUTSTANDING);

    // Credits only shrink while a request waits, so valid never drops before arready.
    assign m_axi_arvalid = (state == REQ) && credit_ok;
    assign ar_hs         = m_axi_arvalid && m_axi_arready;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    credit_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .inc   (ar_hs),
        .dec   (rlast_hs),
        .count (outstanding)
    );

    // Empty and misaligned jobs go through DRAIN with a zero target, which
    // lands done two cycles after the start like any other job end.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_pulse) begin
                    if (!start_ok || mb_num == 16'd0) state_nxt = DRAIN;
                    else                              state_nxt = REQ;
                end
            end
            REQ: begin
                if (ar_hs && (issued + 16'd1) == mb_cnt) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (completed == mb_cnt || completed_nxt == mb_cnt) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mb_cnt       <= '0;
            issued       <= '0;
            completed    <= '0;
            m_axi_araddr <= '0;
            addr_error   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                mb_cnt       <= start_ok ? mb_num : 16'd0;
                issued       <= '0;
                completed    <= '0;
                m_axi_araddr <= src_addr;
                addr_error   <= !start_ok;
            end else begin
                if (ar_hs) begin
                    issued       <= issued + 16'd1;
                    m_axi_araddr <= m_axi_araddr + MB_STRIDE_B;
                end
                if (rl_cnt) completed <= completed_nxt;
            end
        end
    end

endmodule
